// File: rtl/keyboard_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts out 8 data bits + odd parity + stop on device clock falling edges, checks ACK.
module keyboard_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       kbd_clk_in,
  input  logic       kbd_data_in,
  output logic       kbd_clk_oe,
  output logic       kbd_data_oe
);

  localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, BITS, ACK} state_t;

  state_t        state_q;
  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          clk_prev_q;
  logic [8:0]    shift_q;
  logic [IW-1:0] inh_q;
  logic [TW-1:0] tmo_q;
  logic [3:0]    edge_q;
  logic          busy_q, done_q, err_q, clk_oe_q, data_oe_q;

  logic fall;
  logic tmo_hit;

  assign fall    = clk_prev_q & ~clk_sync_q[1];
  assign tmo_hit = (tmo_q == TMO_LAST);

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign kbd_clk_oe  = clk_oe_q;
  assign kbd_data_oe = data_oe_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      shift_q     <= '0;
      inh_q       <= '0;
      tmo_q       <= '0;
      edge_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], kbd_clk_in};
      data_sync_q <= {data_sync_q[0], kbd_data_in};
      clk_prev_q  <= clk_sync_q[1];
      done_q      <= 1'b0;
      err_q       <= 1'b0;

      case (state_q)
        IDLE: begin
          if (tx_start) begin
            shift_q   <= {~^tx_data, tx_data};
            busy_q    <= 1'b1;
            clk_oe_q  <= 1'b1;
            data_oe_q <= 1'b0;
            inh_q     <= '0;
            state_q   <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (inh_q == INH_LAST) begin
            data_oe_q <= 1'b1;
            state_q   <= RTS;
          end else begin
            inh_q <= inh_q + 1'b1;
          end
        end

        RTS: begin
          clk_oe_q <= 1'b0;
          edge_q   <= '0;
          tmo_q    <= '0;
          state_q  <= BITS;
        end

        BITS: begin
          if (tmo_hit) begin
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            data_oe_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (fall) begin
              edge_q <= edge_q + 1'b1;
              // Edges 1-9 shift out data LSB first then parity; edge 10 releases for stop.
              if (edge_q == 4'd9) begin
                data_oe_q <= 1'b0;
                state_q   <= ACK;
              end else begin
                data_oe_q <= ~shift_q[0];
                shift_q   <= {1'b0, shift_q[8:1]};
              end
            end
          end
        end

        ACK: begin
          if (fall) begin
            done_q  <= ~data_sync_q[1];
            err_q   <= data_sync_q[1];
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
          data_oe_q <= 1'b0;
        end

        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
